// File: rtl/mem_arbiter.sv
// Purpose: merges fetch-stage instruction reads and request-unit data reads/writes onto one RAM port.
// Latency: grant registered at the edge after a request; hit combinational on ramrdy (>= 2 cycles request->hit).
// Backpressure: requesters hold requests until hit; RAM stalls via ramrdy, bounded by a timeout abort (bus_err).
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramrdy,
  output logic              bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_TOP    = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     starve, starve_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt, tcnt_inc;
  logic              ren_nxt, wen_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] store_nxt;
  logic              dreq;
  logic              owner_req;

  assign dreq = dREN | dWEN;

  // Read data is only meaningful on the owner's hit; a write completion returns zero.
  assign iload = ihit ? ramload : '0;
  assign dload = (dhit && !ramWEN) ? ramload : '0;

  // Grant arbitration, transaction completion/abort/timeout, and the starvation guard.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    tcnt_nxt   = tcnt;
    tcnt_inc   = tcnt + TW'(1);
    ren_nxt    = ramREN;
    wen_nxt    = ramWEN;
    addr_nxt   = ramaddr;
    store_nxt  = ramstore;
    owner_req  = 1'b0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    bus_err    = 1'b0;
    case (state)
      IDLE: begin
        // An idle instruction side has no starvation history to keep.
        if (!iREN) starve_nxt = '0;
        if (dreq && !(iREN && starve == STARVE_TOP)) begin
          state_nxt = DBUSY;
          ren_nxt   = !dWEN;
          wen_nxt   = dWEN;
          addr_nxt  = daddr;
          store_nxt = dstore;
          tcnt_nxt  = '0;
          if (iREN && starve != STARVE_TOP) starve_nxt = starve + SW'(1);
        end else if (iREN) begin
          state_nxt  = IBUSY;
          ren_nxt    = 1'b1;
          wen_nxt    = 1'b0;
          addr_nxt   = iaddr;
          store_nxt  = '0;
          tcnt_nxt   = '0;
          starve_nxt = '0;
        end
      end
      DBUSY, IBUSY: begin
        owner_req = (state == DBUSY) ? dreq : iREN;
        // A withdrawn request aborts silently, even if the RAM answers this cycle.
        if (owner_req && ramrdy) begin
          ihit = (state == IBUSY);
          dhit = (state == DBUSY);
        end
        if (owner_req && !ramrdy && tcnt_inc == TMO_TOP) bus_err = 1'b1;
        if (!owner_req || ramrdy || tcnt_inc == TMO_TOP) begin
          state_nxt = IDLE;
          ren_nxt   = 1'b0;
          wen_nxt   = 1'b0;
        end else begin
          tcnt_nxt = tcnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        ren_nxt   = 1'b0;
        wen_nxt   = 1'b0;
      end
    endcase
  end

  // State, counters and the registered RAM command; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state    <= IDLE;
      starve   <= '0;
      tcnt     <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      state    <= state_nxt;
      starve   <= starve_nxt;
      tcnt     <= tcnt_nxt;
      ramREN   <= ren_nxt;
      ramWEN   <= wen_nxt;
      ramaddr  <= addr_nxt;
      ramstore <= store_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: randomized scoreboard bench for mem_arbiter against a transaction-level reference model.
// Latency: stimulus driven at negedge, model predicts at +1, monitor compares at +2 of the same cycle.
// Backpressure: requesters hold until hit (optionally withdraw); ramrdy randomized or held low for timeouts.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 15;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          ihit;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dhit;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic          ramrdy = 1'b0;
  logic          bus_err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramrdy(ramrdy), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          ren, wen, ihit, dhit, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] store, load;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0, n_total = 0, cyc = 0;

  // Reference model: one outstanding RAM transaction, who owns it, and how long it has waited.
  bit            m_busy = 0, m_isd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_store = '0;
  int            m_wait = 0, m_streak = 0;
  bit            model_on = 0;

  // Stimulus state and knobs.
  bit            i_pend = 0, d_pend = 0;
  int            d_kind = 0, kind_fix = -1;
  logic [AW-1:0] ia = '0, da = '0;
  logic [DW-1:0] ds = '0;
  int            p_i = 0, p_d = 0, p_drop = 0, p_rdy = 0;
  bit            stall = 0, rst_now = 0;
  bit            last_ihit = 0, last_dhit = 0;
  int            phase = 0, cyc_phase = 0;
  int            drun = 0, n_err_c = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
  endtask

  // Predict this cycle's DUT outputs from the transaction view, then advance it.
  task automatic model_step();
    exp_t e;
    bit   own;
    e.ren   = m_busy && !m_wr;
    e.wen   = m_busy && m_wr;
    e.addr  = m_addr;
    e.store = m_store;
    e.ihit  = 0;
    e.dhit  = 0;
    e.err   = 0;
    e.load  = '0;
    if (m_busy) begin
      own = m_isd ? (dREN | dWEN) : iREN;
      if (!own) m_busy = 0;
      else if (ramrdy) begin
        if (m_isd) e.dhit = 1; else e.ihit = 1;
        e.load = m_wr ? '0 : ramload;
        m_busy = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin e.err = 1; m_busy = 0; end
      end
    end else begin
      if (!iREN) m_streak = 0;
      if ((dREN | dWEN) && !(iREN && m_streak == SMAX)) begin
        m_busy = 1; m_isd = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_wait = 0;
        if (iREN && m_streak < SMAX) m_streak++;
      end else if (iREN) begin
        m_busy = 1; m_isd = 0; m_wr = 0; m_addr = iaddr; m_wait = 0; m_streak = 0;
      end
    end
    if (nRST) begin m_busy = 0; m_streak = 0; end
    expq.push_back(e);
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    cyc_phase = phase;
    if (last_ihit) i_pend = 0;
    if (last_dhit) d_pend = 0;
    if (i_pend && $urandom_range(99) < p_drop) i_pend = 0;
    if (d_pend && $urandom_range(99) < p_drop) d_pend = 0;
    if (!i_pend && $urandom_range(99) < p_i) begin
      i_pend = 1;
      ia = AW'($urandom_range(1023)) << 2;
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1;
      da = AW'($urandom_range(1023)) << 2;
      ds = $urandom;
      d_kind = (kind_fix >= 0) ? kind_fix : int'($urandom_range(2));
    end
    // Address wiggle while held: the arbiter must keep the latched address.
    if (i_pend && $urandom_range(99) < 5) ia = $urandom;
    if (d_pend && $urandom_range(99) < 5) da = $urandom;
    iREN    = i_pend;
    iaddr   = ia;
    dREN    = d_pend && d_kind != 1;
    dWEN    = d_pend && d_kind != 0;
    daddr   = da;
    dstore  = ds;
    ramrdy  = !stall && ($urandom_range(99) < p_rdy);
    ramload = $urandom;
    nRST    = rst_now;
    #1;
    if (model_on) model_step();
  endtask

  // Monitor: pop one expectation per modelled cycle and compare the visible outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      last_ihit = ihit;
      last_dhit = dhit;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ramREN", 32'(ramREN), 32'(e.ren));
        chk("ramWEN", 32'(ramWEN), 32'(e.wen));
        if (e.ren || e.wen) chk("ramaddr", ramaddr, e.addr);
        if (e.wen) chk("ramstore", ramstore, e.store);
        chk("ihit", 32'(ihit), 32'(e.ihit));
        chk("dhit", 32'(dhit), 32'(e.dhit));
        chk("bus_err", 32'(bus_err), 32'(e.err));
        if (e.ihit) chk("iload", iload, e.load);
        if (e.dhit) chk("dload", dload, e.load);
      end
      if (cyc_phase == 2) begin
        if (dhit) drun++;
        if (ihit) begin
          chk("starve_run", drun, SMAX);
          drun = 0;
        end
      end
      if (cyc_phase == 3 && bus_err) n_err_c++;
    end
  end

  initial begin
    // Reset held two cycles with both requests up.
    i_pend = 1; d_pend = 1; d_kind = 0; p_i = 100; p_d = 100; stall = 1; rst_now = 1;
    step();
    model_on = 1;
    step();
    rst_now = 0; stall = 0;

    // Instruction-only traffic with a variable RAM.
    phase = 1; d_pend = 0; p_i = 60; p_d = 0; p_rdy = 40;
    repeat (40) step();

    // Starvation guard: both sides saturated, every access completes at once.
    phase = 2; drun = 0; p_i = 100; p_d = 100; p_drop = 0; p_rdy = 100;
    stall = 1; rst_now = 1; step();
    stall = 0; rst_now = 0;
    repeat (80) step();

    // Timeout: a data read against a RAM that never answers.
    phase = 3; i_pend = 0; p_i = 0; d_pend = 1; d_kind = 0; kind_fix = 0; p_d = 100;
    stall = 1; rst_now = 1; step();
    rst_now = 0;
    repeat (40) step();
    chk("timeout_count", n_err_c, 2);

    // Reset in the middle of a busy read+write request; write must win afterwards.
    phase = 4; d_pend = 1; d_kind = 2; kind_fix = 2;
    repeat (4) step();
    rst_now = 1; step();
    rst_now = 0; stall = 0; p_rdy = 100;
    repeat (6) step();
    kind_fix = -1;

    // Free-running random traffic with aborts, varying RAM speed and rare resets.
    phase = 5; p_i = 30; p_d = 30; p_drop = 3;
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(2))
        0:       p_rdy = 4;
        1:       p_rdy = 35;
        default: p_rdy = 80;
      endcase
      for (int k = 0; k < 100; k++) begin
        rst_now = ($urandom_range(499) == 0);
        step();
      end
    end
    rst_now = 0;
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
